// File: rtl/seq_trig_pkg.sv
// Shared types and helpers for the sequence trigger generator.
// Default counter width, FSM state encoding and the masked pattern compare.
package seq_trig_pkg;

    localparam int SEQ_TRIG_CNT_WIDTH_DEF = 16;
    localparam int SEQ_TRIG_MAX_BITS      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_FIRE,
        ST_HOLDOFF
    } seq_trig_state_t;

    // Callers zero-extend narrower words; a cleared mask bit never causes a mismatch.
    function automatic logic seq_match(
        input logic [SEQ_TRIG_MAX_BITS-1:0] value,
        input logic [SEQ_TRIG_MAX_BITS-1:0] mask,
        input logic [SEQ_TRIG_MAX_BITS-1:0] sample
    );
        return (((sample ^ value) & mask) == '0);
    endfunction

endpackage

// File: rtl/seq_trig_qual.sv
// Input sample stage and run qualifier: registers the sample, compares it against the
// latched pattern and raises a combinational strobe on the sample that completes the run.
module seq_trig_qual
    import seq_trig_pkg::*;
#(
    parameter int IN_BITS   = 8,
    parameter int CNT_WIDTH = SEQ_TRIG_CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_BITS-1:0]   i_data,
    input  logic                 i_active,
    input  logic [IN_BITS-1:0]   i_cfg_match,
    input  logic [IN_BITS-1:0]   i_cfg_mask,
    input  logic                 i_cfg_edge,
    input  logic [CNT_WIDTH-1:0] i_cfg_count,
    output logic [IN_BITS-1:0]   o_s1,
    output logic                 o_qualify
);

    localparam logic [CNT_WIDTH-1:0] C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [IN_BITS-1:0]   r_s1;
    logic [CNT_WIDTH-1:0] r_run_cnt;
    logic                 r_seen_nomatch;
    logic                 w_match;
    logic                 w_counts;
    logic [CNT_WIDTH-1:0] w_run_inc;
    logic [CNT_WIDTH-1:0] w_target;

    assign w_match   = seq_match(SEQ_TRIG_MAX_BITS'(i_cfg_match),
                                 SEQ_TRIG_MAX_BITS'(i_cfg_mask),
                                 SEQ_TRIG_MAX_BITS'(r_s1));
    // In edge mode a match only counts once a non-matching sample has been seen.
    assign w_counts  = w_match && (!i_cfg_edge || r_seen_nomatch);
    assign w_run_inc = (&r_run_cnt) ? r_run_cnt : (r_run_cnt + C_ONE);
    assign w_target  = (i_cfg_count == '0) ? C_ONE : i_cfg_count;
    assign o_qualify = i_active && w_counts && (w_run_inc >= w_target);
    assign o_s1      = r_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1           <= '0;
            r_run_cnt      <= '0;
            r_seen_nomatch <= 1'b0;
        end else begin
            r_s1 <= i_data;
            // Outside ARMED the run state is held clear, so every re-arm starts fresh.
            if (!i_active) begin
                r_run_cnt      <= '0;
                r_seen_nomatch <= 1'b0;
            end else if (!w_match) begin
                r_run_cnt      <= '0;
                r_seen_nomatch <= 1'b1;
            end else if (w_counts) begin
                r_run_cnt <= w_run_inc;
            end
        end
    end

endmodule

// File: rtl/seq_trig_gen.sv
// Trigger generator in front of the sequence recorder: qualified pattern match, delay,
// holdoff, and a 2-cycle data pipeline aligned to the pulse. SEQ_TRIG_CNT_EN adds TRIG_CNT.
module seq_trig_gen
    import seq_trig_pkg::*;
#(
    parameter int IN_BITS   = 8,
    parameter int CNT_WIDTH = SEQ_TRIG_CNT_WIDTH_DEF
) (
    input  logic                 SEQ_CLK,
    input  logic                 SEQ_RST_N,
    input  logic [IN_BITS-1:0]   SEQ_IN,
    input  logic [IN_BITS-1:0]   CONF_MATCH,
    input  logic [IN_BITS-1:0]   CONF_MASK,
    input  logic                 CONF_EDGE,
    input  logic                 CONF_ONESHOT,
    input  logic [CNT_WIDTH-1:0] CONF_MATCH_COUNT,
    input  logic [CNT_WIDTH-1:0] CONF_DELAY,
    input  logic [CNT_WIDTH-1:0] CONF_HOLDOFF,
    input  logic                 ARM,
    input  logic                 DISARM,
    output logic [IN_BITS-1:0]   SEQ_OUT,
    output logic                 SEQ_EXT_START,
    output logic                 ARMED,
`ifdef SEQ_TRIG_CNT_EN
    output logic [CNT_WIDTH-1:0] TRIG_CNT,
`endif
    output logic                 BUSY
);

    localparam logic [CNT_WIDTH-1:0] C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    seq_trig_state_t      r_state;
    seq_trig_state_t      w_state_next;
    logic [IN_BITS-1:0]   r_seq_out;
    logic                 r_start;
    logic                 r_armed;
    logic                 r_busy;
    logic [CNT_WIDTH-1:0] r_dly_cnt;
    logic [CNT_WIDTH-1:0] r_hold_cnt;
    logic [IN_BITS-1:0]   r_cfg_match;
    logic [IN_BITS-1:0]   r_cfg_mask;
    logic                 r_cfg_edge;
    logic                 r_cfg_oneshot;
    logic [CNT_WIDTH-1:0] r_cfg_count;
    logic [CNT_WIDTH-1:0] r_cfg_delay;
    logic [CNT_WIDTH-1:0] r_cfg_holdoff;
    logic [IN_BITS-1:0]   w_s1;
    logic                 w_qualify;
    logic                 w_qual_active;
    logic                 w_arm_accept;

    assign w_qual_active = (r_state == ST_ARMED);
    assign w_arm_accept  = (r_state == ST_IDLE) && ARM && !DISARM;

    seq_trig_qual #(
        .IN_BITS   (IN_BITS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_qual (
        .clk         (SEQ_CLK),
        .rst_n       (SEQ_RST_N),
        .i_data      (SEQ_IN),
        .i_active    (w_qual_active),
        .i_cfg_match (r_cfg_match),
        .i_cfg_mask  (r_cfg_mask),
        .i_cfg_edge  (r_cfg_edge),
        .i_cfg_count (r_cfg_count),
        .o_s1        (w_s1),
        .o_qualify   (w_qualify)
    );

    always_comb begin
        w_state_next = r_state;
        if (DISARM) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (ARM) w_state_next = ST_ARMED;
                ST_ARMED:   if (w_qualify) w_state_next = (r_cfg_delay == '0) ? ST_FIRE : ST_DELAY;
                ST_DELAY:   if (r_dly_cnt <= C_ONE) w_state_next = ST_FIRE;
                ST_FIRE: begin
                    if (r_cfg_oneshot)             w_state_next = ST_IDLE;
                    else if (r_cfg_holdoff == '0)  w_state_next = ST_ARMED;
                    else                           w_state_next = ST_HOLDOFF;
                end
                ST_HOLDOFF: if (r_hold_cnt <= C_ONE) w_state_next = ST_ARMED;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge SEQ_CLK or negedge SEQ_RST_N) begin
        if (!SEQ_RST_N) begin
            r_state       <= ST_IDLE;
            r_seq_out     <= '0;
            r_start       <= 1'b0;
            r_armed       <= 1'b0;
            r_busy        <= 1'b0;
            r_dly_cnt     <= '0;
            r_hold_cnt    <= '0;
            r_cfg_match   <= '0;
            r_cfg_mask    <= '0;
            r_cfg_edge    <= 1'b0;
            r_cfg_oneshot <= 1'b0;
            r_cfg_count   <= '0;
            r_cfg_delay   <= '0;
            r_cfg_holdoff <= '0;
        end else begin
            r_state   <= w_state_next;
            r_seq_out <= w_s1;
            r_start   <= (w_state_next == ST_FIRE);
            r_armed   <= (w_state_next == ST_ARMED);
            r_busy    <= (w_state_next != ST_IDLE);

            if (w_arm_accept) begin
                r_cfg_match   <= CONF_MATCH;
                r_cfg_mask    <= CONF_MASK;
                r_cfg_edge    <= CONF_EDGE;
                r_cfg_oneshot <= CONF_ONESHOT;
                r_cfg_count   <= CONF_MATCH_COUNT;
                r_cfg_delay   <= CONF_DELAY;
                r_cfg_holdoff <= CONF_HOLDOFF;
            end

            if (r_state == ST_ARMED && w_state_next == ST_DELAY)
                r_dly_cnt <= r_cfg_delay;
            else if (r_state == ST_DELAY && r_dly_cnt != '0)
                r_dly_cnt <= r_dly_cnt - C_ONE;

            if (r_state == ST_FIRE)
                r_hold_cnt <= r_cfg_holdoff;
            else if (r_state == ST_HOLDOFF && r_hold_cnt != '0)
                r_hold_cnt <= r_hold_cnt - C_ONE;
        end
    end

`ifdef SEQ_TRIG_CNT_EN
    logic [CNT_WIDTH-1:0] r_trig_cnt;

    always_ff @(posedge SEQ_CLK or negedge SEQ_RST_N) begin
        if (!SEQ_RST_N)
            r_trig_cnt <= '0;
        else if (w_arm_accept)
            r_trig_cnt <= '0;
        else if (r_state == ST_FIRE && !(&r_trig_cnt))
            r_trig_cnt <= r_trig_cnt + C_ONE;
    end

    assign TRIG_CNT = r_trig_cnt;
`endif

    assign SEQ_OUT       = r_seq_out;
    assign SEQ_EXT_START = r_start;
    assign ARMED         = r_armed;
    assign BUSY          = r_busy;

endmodule

// File: tb/tb_seq_trig_gen.sv
// Directed bench for seq_trig_gen: a vector table for the basic match paths plus
// hand-written sequences for edge mode, holdoff, delay, disarm, reset and TRIG_CNT.
module tb_seq_trig_gen;

    localparam int IN_BITS   = 8;
    localparam int CNT_WIDTH = 16;

    logic                 SEQ_CLK = 1'b0;
    logic                 SEQ_RST_N;
    logic [IN_BITS-1:0]   SEQ_IN;
    logic [IN_BITS-1:0]   CONF_MATCH;
    logic [IN_BITS-1:0]   CONF_MASK;
    logic                 CONF_EDGE;
    logic                 CONF_ONESHOT;
    logic [CNT_WIDTH-1:0] CONF_MATCH_COUNT;
    logic [CNT_WIDTH-1:0] CONF_DELAY;
    logic [CNT_WIDTH-1:0] CONF_HOLDOFF;
    logic                 ARM;
    logic                 DISARM;
    logic [IN_BITS-1:0]   SEQ_OUT;
    logic                 SEQ_EXT_START;
    logic                 ARMED;
    logic                 BUSY;
`ifdef SEQ_TRIG_CNT_EN
    logic [CNT_WIDTH-1:0] TRIG_CNT;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]  din;
        logic        arm;
        logic        disarm;
        logic [7:0]  cmatch;
        logic [7:0]  cmask;
        logic [15:0] ccount;
        logic        exp_start;
        logic [7:0]  exp_out;
        logic        exp_armed;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    seq_trig_gen #(
        .IN_BITS   (IN_BITS),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .SEQ_CLK          (SEQ_CLK),
        .SEQ_RST_N        (SEQ_RST_N),
        .SEQ_IN           (SEQ_IN),
        .CONF_MATCH       (CONF_MATCH),
        .CONF_MASK        (CONF_MASK),
        .CONF_EDGE        (CONF_EDGE),
        .CONF_ONESHOT     (CONF_ONESHOT),
        .CONF_MATCH_COUNT (CONF_MATCH_COUNT),
        .CONF_DELAY       (CONF_DELAY),
        .CONF_HOLDOFF     (CONF_HOLDOFF),
        .ARM              (ARM),
        .DISARM           (DISARM),
        .SEQ_OUT          (SEQ_OUT),
        .SEQ_EXT_START    (SEQ_EXT_START),
        .ARMED            (ARMED),
`ifdef SEQ_TRIG_CNT_EN
        .TRIG_CNT         (TRIG_CNT),
`endif
        .BUSY             (BUSY)
    );

    always #5 SEQ_CLK = ~SEQ_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] din, input logic arm, input logic disarm);
        SEQ_IN = din;
        ARM    = arm;
        DISARM = disarm;
        @(posedge SEQ_CLK);
        #1;
        ARM    = 1'b0;
        DISARM = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] m, input logic [7:0] k, input logic [15:0] cnt,
                           input logic edg, input logic one, input logic [15:0] dly,
                           input logic [15:0] hold);
        CONF_MATCH       = m;
        CONF_MASK        = k;
        CONF_MATCH_COUNT = cnt;
        CONF_EDGE        = edg;
        CONF_ONESHOT     = one;
        CONF_DELAY       = dly;
        CONF_HOLDOFF     = hold;
    endtask

    function automatic vec_t mk(input logic [7:0] din, input logic arm, input logic disarm,
                                input logic [7:0] cm, input logic [7:0] ck, input logic [15:0] cc,
                                input logic es, input logic [7:0] eo, input logic ea, input logic eb);
        vec_t v;
        v.din = din; v.arm = arm; v.disarm = disarm;
        v.cmatch = cm; v.cmask = ck; v.ccount = cc;
        v.exp_start = es; v.exp_out = eo; v.exp_armed = ea; v.exp_busy = eb;
        return v;
    endfunction

    initial begin
        int pulses;
        int last;
        int bad;

        // count=1 exact match, then count=3 masked run, then ARM+DISARM together
        vecs.push_back(mk(8'h00, 1'b1, 1'b0, 8'hA5, 8'hFF, 16'd1, 1'b0, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(8'hA5, 1'b0, 1'b0, 8'hA5, 8'hFF, 16'd1, 1'b0, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'hA5, 8'hFF, 16'd1, 1'b1, 8'hA5, 1'b0, 1'b1));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'hA5, 8'hFF, 16'd1, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b1, 1'b0, 8'h50, 8'hF0, 16'd3, 1'b0, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(8'h51, 1'b0, 1'b0, 8'h50, 8'hF0, 16'd3, 1'b0, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(8'h52, 1'b0, 1'b0, 8'h50, 8'hF0, 16'd3, 1'b0, 8'h51, 1'b1, 1'b1));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h50, 8'hF0, 16'd3, 1'b0, 8'h52, 1'b1, 1'b1));
        vecs.push_back(mk(8'h53, 1'b0, 1'b0, 8'h50, 8'hF0, 16'd3, 1'b0, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(8'h54, 1'b0, 1'b0, 8'h50, 8'hF0, 16'd3, 1'b0, 8'h53, 1'b1, 1'b1));
        vecs.push_back(mk(8'h55, 1'b0, 1'b0, 8'h50, 8'hF0, 16'd3, 1'b0, 8'h54, 1'b1, 1'b1));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h50, 8'hF0, 16'd3, 1'b1, 8'h55, 1'b0, 1'b1));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h50, 8'hF0, 16'd3, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 16'd1, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 16'd1, 1'b0, 8'h00, 1'b0, 1'b0));

        SEQ_RST_N = 1'b0;
        SEQ_IN = '0; ARM = 1'b0; DISARM = 1'b0;
        set_cfg(8'h00, 8'h00, 16'd1, 1'b0, 1'b1, 16'd0, 16'd0);
        #12;
        check("reset start", 32'(SEQ_EXT_START), 32'd0);
        check("reset out",   32'(SEQ_OUT),       32'd0);
        check("reset armed", 32'(ARMED),         32'd0);
        check("reset busy",  32'(BUSY),          32'd0);
`ifdef SEQ_TRIG_CNT_EN
        check("reset trig_cnt", 32'(TRIG_CNT), 32'd0);
`endif
        SEQ_RST_N = 1'b1;
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            CONF_MATCH       = vecs[i].cmatch;
            CONF_MASK        = vecs[i].cmask;
            CONF_MATCH_COUNT = vecs[i].ccount;
            step(vecs[i].din, vecs[i].arm, vecs[i].disarm);
            $display("vec%0d in=%02h arm=%0b dis=%0b -> start=%0b out=%02h armed=%0b busy=%0b",
                     i, vecs[i].din, vecs[i].arm, vecs[i].disarm, SEQ_EXT_START, SEQ_OUT, ARMED, BUSY);
            check($sformatf("vec%0d start", i), 32'(SEQ_EXT_START), 32'(vecs[i].exp_start));
            check($sformatf("vec%0d out", i),   32'(SEQ_OUT),       32'(vecs[i].exp_out));
            check($sformatf("vec%0d armed", i), 32'(ARMED),         32'(vecs[i].exp_armed));
            check($sformatf("vec%0d busy", i),  32'(BUSY),          32'(vecs[i].exp_busy));
        end

        // Edge mode: armed while already matching, needs a non-match first
        set_cfg(8'hA5, 8'hFF, 16'd1, 1'b1, 1'b1, 16'd0, 16'd0);
        step(8'hA5, 1'b0, 1'b0);
        step(8'hA5, 1'b0, 1'b0);
        step(8'hA5, 1'b1, 1'b0);
        check("edge armed", 32'(ARMED), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(8'hA5, 1'b0, 1'b0);
            check($sformatf("edge held%0d start", i), 32'(SEQ_EXT_START), 32'd0);
        end
        step(8'h00, 1'b0, 1'b0);
        check("edge nomatch start", 32'(SEQ_EXT_START), 32'd0);
        step(8'hA5, 1'b0, 1'b0);
        check("edge second start", 32'(SEQ_EXT_START), 32'd0);
        step(8'h00, 1'b0, 1'b0);
        $display("edge pulse: start=%0b out=%02h", SEQ_EXT_START, SEQ_OUT);
        check("edge fire start", 32'(SEQ_EXT_START), 32'd1);
        check("edge fire out",   32'(SEQ_OUT),       32'hA5);
        step(8'h00, 1'b0, 1'b0);
        check("edge oneshot busy", 32'(BUSY), 32'd0);

        // Re-arm with holdoff 4 and constant match; an ARM during holdoff is ignored
        set_cfg(8'hA5, 8'hFF, 16'd1, 1'b0, 1'b0, 16'd0, 16'd4);
        step(8'hA5, 1'b0, 1'b0);
        step(8'hA5, 1'b1, 1'b0);
        pulses = 0;
        last = -1;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 10) CONF_ONESHOT = 1'b1;
            step(8'hA5, (k == 10), 1'b0);
            CONF_ONESHOT = 1'b0;
            if (!BUSY) bad++;
            if (SEQ_EXT_START) begin
                $display("holdoff pulse at k=%0d", k);
                if (last >= 0) check($sformatf("holdoff period k%0d", k), 32'(k - last), 32'd6);
                last = k;
                pulses++;
            end
        end
        check("holdoff pulse count", 32'(pulses), 32'd5);
        check("holdoff busy drops", 32'(bad), 32'd0);
        step(8'hA5, 1'b0, 1'b1);
        check("holdoff disarm busy",  32'(BUSY),  32'd0);
        check("holdoff disarm armed", 32'(ARMED), 32'd0);

        // Delay 3 shifts the pulse by three cycles
        set_cfg(8'hA5, 8'hFF, 16'd1, 1'b0, 1'b1, 16'd3, 16'd0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'hA5, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check("dly3 qual start", 32'(SEQ_EXT_START), 32'd0);
        check("dly3 qual busy",  32'(BUSY),          32'd1);
        check("dly3 qual armed", 32'(ARMED),         32'd0);
        step(8'h00, 1'b0, 1'b0);
        check("dly3 d1 start", 32'(SEQ_EXT_START), 32'd0);
        step(8'h00, 1'b0, 1'b0);
        check("dly3 d2 start", 32'(SEQ_EXT_START), 32'd0);
        step(8'h00, 1'b0, 1'b0);
        $display("dly3 pulse: start=%0b busy=%0b", SEQ_EXT_START, BUSY);
        check("dly3 fire start", 32'(SEQ_EXT_START), 32'd1);
        step(8'h00, 1'b0, 1'b0);
        check("dly3 after busy", 32'(BUSY), 32'd0);

        // Delay 10 aborted by DISARM five cycles after qualification
        set_cfg(8'hA5, 8'hFF, 16'd1, 1'b0, 1'b1, 16'd10, 16'd0);
        step(8'h00, 1'b1, 1'b0);
        step(8'hA5, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(8'h00, 1'b0, 1'b0);
            check($sformatf("dly10 wait%0d busy", i), 32'(BUSY), 32'd1);
        end
        step(8'h00, 1'b0, 1'b1);
        check("dly10 disarm busy",  32'(BUSY),          32'd0);
        check("dly10 disarm start", 32'(SEQ_EXT_START), 32'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step(8'h00, 1'b0, 1'b0);
            if (SEQ_EXT_START || BUSY) bad++;
        end
        check("dly10 no late pulse", 32'(bad), 32'd0);

        // Asynchronous reset while in DELAY
        step(8'hA5, 1'b1, 1'b0);
        step(8'hA5, 1'b0, 1'b0);
        step(8'hA5, 1'b0, 1'b0);
        step(8'hA5, 1'b0, 1'b0);
        check("rst pre busy", 32'(BUSY),    32'd1);
        check("rst pre out",  32'(SEQ_OUT), 32'hA5);
        #2;
        SEQ_RST_N = 1'b0;
        #1;
        $display("async reset: start=%0b out=%02h armed=%0b busy=%0b", SEQ_EXT_START, SEQ_OUT, ARMED, BUSY);
        check("rst mid start", 32'(SEQ_EXT_START), 32'd0);
        check("rst mid out",   32'(SEQ_OUT),       32'd0);
        check("rst mid armed", 32'(ARMED),         32'd0);
        check("rst mid busy",  32'(BUSY),          32'd0);
        step(8'hA5, 1'b0, 1'b0);
        SEQ_RST_N = 1'b1;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            step(8'hA5, 1'b0, 1'b0);
            if (SEQ_EXT_START || BUSY) bad++;
        end
        check("rst no pulse after", 32'(bad), 32'd0);

`ifdef SEQ_TRIG_CNT_EN
        // Three fires counted, then cleared by the next ARM
        set_cfg(8'hA5, 8'hFF, 16'd1, 1'b0, 1'b0, 16'd0, 16'd0);
        step(8'hA5, 1'b1, 1'b0);
        check("tc arm clear", 32'(TRIG_CNT), 32'd0);
        pulses = 0;
        for (int k = 0; k < 20 && pulses < 3; k++) begin
            step(8'hA5, 1'b0, 1'b0);
            if (SEQ_EXT_START) pulses++;
        end
        check("tc pulses seen", 32'(pulses), 32'd3);
        step(8'hA5, 1'b0, 1'b1);
        $display("trig_cnt after 3 fires = %0d", TRIG_CNT);
        check("tc three", 32'(TRIG_CNT), 32'd3);
        check("tc idle busy", 32'(BUSY), 32'd0);
        step(8'hA5, 1'b1, 1'b0);
        check("tc rearm clear", 32'(TRIG_CNT), 32'd0);
        step(8'hA5, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
